// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter_if
// Brief    : ALU, load, scoreboard and register-file write-port bundle for
//            rf_wb_arbiter.
// Revision : 1.0
// ============================================================================
interface rf_wb_arbiter_if #(
    parameter int LQ_DEPTH = 2
) ();
    localparam int c_CW = $clog2(LQ_DEPTH) + 1;

    logic            i_alu_valid;
    logic [4:0]      i_alu_rd;
    logic [31:0]     i_alu_data;
    logic            i_ld_valid;
    logic            o_ld_ready;
    logic [4:0]      i_ld_rd;
    logic [31:0]     i_ld_data;
    logic            i_iss_valid;
    logic [4:0]      i_iss_rd;
    logic [4:0]      i_chk_addr1;
    logic [4:0]      i_chk_addr2;
    logic            o_busy1;
    logic            o_busy2;
    logic            o_alu_stall;
    logic [4:0]      o_wr_addr;
    logic [31:0]     o_wr_data;
    logic            o_wr_en;
    logic [c_CW-1:0] o_lq_count;

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_ld_valid, i_ld_rd, i_ld_data,
        input  i_iss_valid, i_iss_rd, i_chk_addr1, i_chk_addr2,
        output o_ld_ready, o_busy1, o_busy2, o_alu_stall,
        output o_wr_addr, o_wr_data, o_wr_en, o_lq_count
    );

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_ld_valid, i_ld_rd, i_ld_data,
        output i_iss_valid, i_iss_rd, i_chk_addr1, i_chk_addr2,
        input  o_ld_ready, o_busy1, o_busy2, o_alu_stall,
        input  o_wr_addr, o_wr_data, o_wr_en, o_lq_count
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Register-file write-back arbiter merging ALU results with queued
//            load results; optional busy-bit scoreboard (RF_WB_SCOREBOARD_EN).
// Revision : 1.0
// ============================================================================
module rf_wb_arbiter #(
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           i_rst_n,
    rf_wb_arbiter_if.slave bus
);
    localparam int c_PW = $clog2(LQ_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_SW = $clog2(STARVE_MAX) + 1;
    localparam logic [c_CW-1:0] c_DEPTH      = c_CW'(LQ_DEPTH);
    localparam logic [c_SW-1:0] c_STARVE_LIM = c_SW'(STARVE_MAX - 1);

    logic [c_CW-1:0] r_count;
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [4:0]      r_q_rd   [LQ_DEPTH];
    logic [31:0]     r_q_data [LQ_DEPTH];
    logic [c_SW-1:0] r_starve;
    logic            r_alu_stall;
    logic            r_live;
    logic            r_wr_en;
    logic [4:0]      r_wr_addr;
    logic [31:0]     r_wr_data;

    logic            w_ld_ready;
    logic            w_full;
    logic            w_nonempty;
    logic            w_enq;
    logic            w_deq;
    logic            w_alu_sel;
    logic [4:0]      w_head_rd;
    logic [31:0]     w_head_data;

    assign w_ld_ready  = (r_count < c_DEPTH);
    assign w_full      = (r_count == c_DEPTH);
    assign w_nonempty  = (r_count != '0);
    assign w_enq       = bus.i_ld_valid && w_ld_ready && (bus.i_ld_rd != 5'd0);
    assign w_head_rd   = r_q_rd[r_rptr];
    assign w_head_data = r_q_data[r_rptr];

    // r_live keeps the slot idle until the first edge after reset release.
    always_comb begin
        w_deq     = 1'b0;
        w_alu_sel = 1'b0;
        if (r_live) begin
            if (r_alu_stall && w_nonempty) begin
                w_deq = 1'b1;
            end else if (bus.i_alu_valid && (bus.i_alu_rd != 5'd0) && !r_alu_stall) begin
                w_alu_sel = 1'b1;
            end else if (w_nonempty) begin
                w_deq = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_starve    <= '0;
            r_alu_stall <= 1'b0;
            r_live      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 5'd0;
            r_wr_data   <= 32'd0;
        end else begin
            r_live <= 1'b1;
            if (w_enq) r_wptr <= r_wptr + c_PW'(1);
            if (w_deq) r_rptr <= r_rptr + c_PW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: ;
            endcase

            if (w_full && !w_deq) begin
                if (r_starve != c_STARVE_LIM) r_starve <= r_starve + c_SW'(1);
            end else begin
                r_starve <= '0;
            end
            r_alu_stall <= w_full && !w_deq && (r_starve == c_STARVE_LIM);

            r_wr_en <= w_deq || w_alu_sel;
            if (w_deq) begin
                r_wr_addr <= w_head_rd;
                r_wr_data <= w_head_data;
            end else if (w_alu_sel) begin
                r_wr_addr <= bus.i_alu_rd;
                r_wr_data <= bus.i_alu_data;
            end
        end
    end

    // Queue storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_rd[r_wptr]   <= bus.i_ld_rd;
            r_q_data[r_wptr] <= bus.i_ld_data;
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;

    // Set is applied after clear so a same-edge reissue keeps the bit high.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_deq) w_busy_nxt[w_head_rd] = 1'b0;
        if (bus.i_iss_valid) w_busy_nxt[bus.i_iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) r_busy <= 32'd0;
        else          r_busy <= w_busy_nxt;
    end

    assign bus.o_busy1 = r_busy[bus.i_chk_addr1];
    assign bus.o_busy2 = r_busy[bus.i_chk_addr2];
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{bus.i_iss_valid, bus.i_iss_rd, bus.i_chk_addr1, bus.i_chk_addr2};
    assign bus.o_busy1 = 1'b0;
    assign bus.o_busy2 = 1'b0;
`endif

    assign bus.o_ld_ready  = w_ld_ready;
    assign bus.o_alu_stall = r_alu_stall;
    assign bus.o_wr_en     = r_wr_en;
    assign bus.o_wr_addr   = r_wr_addr;
    assign bus.o_wr_data   = r_wr_data;
    assign bus.o_lq_count  = r_count;
endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Directed self-checking bench for rf_wb_arbiter (LQ_DEPTH=2,
//            STARVE_MAX=4); busy expectations follow RF_WB_SCOREBOARD_EN.
// Revision : 1.0
// ============================================================================
module tb_rf_wb_arbiter;
`ifdef RF_WB_SCOREBOARD_EN
    localparam logic c_SB = 1'b1;
`else
    localparam logic c_SB = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    rf_wb_arbiter_if #(.LQ_DEPTH(2)) bus ();

    rf_wb_arbiter #(.LQ_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_alu_valid = 1'b0; bus.i_alu_rd = 5'd0; bus.i_alu_data = 32'd0;
        bus.i_ld_valid  = 1'b0; bus.i_ld_rd  = 5'd0; bus.i_ld_data  = 32'd0;
        bus.i_iss_valid = 1'b0; bus.i_iss_rd = 5'd0;
        bus.i_chk_addr1 = 5'd0; bus.i_chk_addr2 = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.i_chk_addr1 = 5'd5;
        rst_n = 1'b0;
        repeat (2) step();
        tests++; if (bus.o_wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %0h exp 0", bus.o_wr_en); end
        tests++; if (bus.o_wr_addr !== 5'd0) begin fails++; $display("FAIL rst_wr_addr: got %0h exp 0", bus.o_wr_addr); end
        tests++; if (bus.o_wr_data !== 32'd0) begin fails++; $display("FAIL rst_wr_data: got %0h exp 0", bus.o_wr_data); end
        tests++; if (bus.o_lq_count !== 2'd0) begin fails++; $display("FAIL rst_count: got %0h exp 0", bus.o_lq_count); end
        tests++; if (bus.o_ld_ready !== 1'b1) begin fails++; $display("FAIL rst_ld_ready: got %0h exp 1", bus.o_ld_ready); end
        tests++; if (bus.o_alu_stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %0h exp 0", bus.o_alu_stall); end
        tests++; if (bus.o_busy1 !== 1'b0) begin fails++; $display("FAIL rst_busy1: got %0h exp 0", bus.o_busy1); end
        // ALU result offered before the first edge after release must not write.
        rst_n = 1'b1;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd5; bus.i_alu_data = 32'hAAAA_0000;
        step();
        bus.i_alu_valid = 1'b0;
        tests++; if (bus.o_wr_en !== 1'b0) begin fails++; $display("FAIL rst_first_edge_wr: got %0h exp 0", bus.o_wr_en); end
        step();
    endtask

    task automatic test_alu();
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd5; bus.i_alu_data = 32'hDEAD_BEEF;
        step();
        bus.i_alu_rd = 5'd0; bus.i_alu_data = 32'h0000_0055;
        tests++; if (bus.o_wr_en !== 1'b1) begin fails++; $display("FAIL alu_wr_en: got %0h exp 1", bus.o_wr_en); end
        tests++; if (bus.o_wr_addr !== 5'd5) begin fails++; $display("FAIL alu_wr_addr: got %0h exp 5", bus.o_wr_addr); end
        tests++; if (bus.o_wr_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL alu_wr_data: got %0h exp deadbeef", bus.o_wr_data); end
        step();
        bus.i_alu_valid = 1'b0;
        tests++; if (bus.o_wr_en !== 1'b0) begin fails++; $display("FAIL alu_rd0_wr_en: got %0h exp 0", bus.o_wr_en); end
        tests++; if (bus.o_wr_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL alu_hold_data: got %0h exp deadbeef", bus.o_wr_data); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'(i); bus.i_alu_data = 32'h100 + 32'(i);
            step();
            tests++;
            if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 5'(i) || bus.o_wr_data !== 32'h100 + 32'(i)) begin
                fails++;
                $display("FAIL b2b_%0d: got en=%0h addr=%0h data=%0h exp en=1 addr=%0h data=%0h",
                         i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, i, 32'h100 + 32'(i));
            end
        end
        bus.i_alu_valid = 1'b0;
        step();
    endtask

    task automatic test_load();
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd7; bus.i_ld_data = 32'h1234;
        step();
        bus.i_ld_valid = 1'b0;
        tests++; if (bus.o_lq_count !== 2'd1) begin fails++; $display("FAIL ld_count1: got %0h exp 1", bus.o_lq_count); end
        tests++; if (bus.o_wr_en !== 1'b0) begin fails++; $display("FAIL ld_early_wr: got %0h exp 0", bus.o_wr_en); end
        step();
        tests++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 5'd7 || bus.o_wr_data !== 32'h1234) begin
            fails++; $display("FAIL ld_write: got en=%0h addr=%0h data=%0h exp en=1 addr=7 data=1234", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        tests++; if (bus.o_lq_count !== 2'd0) begin fails++; $display("FAIL ld_count0: got %0h exp 0", bus.o_lq_count); end
        // A load to x0 is consumed without entering the queue.
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd0; bus.i_ld_data = 32'h5555;
        step();
        bus.i_ld_valid = 1'b0;
        tests++; if (bus.o_lq_count !== 2'd0) begin fails++; $display("FAIL ld_x0_count: got %0h exp 0", bus.o_lq_count); end
        step();
        tests++; if (bus.o_wr_en !== 1'b0) begin fails++; $display("FAIL ld_x0_wr: got %0h exp 0", bus.o_wr_en); end
        // ALU outranks a waiting load; the load follows one cycle later.
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd8; bus.i_ld_data = 32'h8888;
        step();
        bus.i_ld_valid = 1'b0;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd2; bus.i_alu_data = 32'h22;
        step();
        bus.i_alu_valid = 1'b0;
        tests++; if (bus.o_wr_addr !== 5'd2 || bus.o_lq_count !== 2'd1) begin
            fails++; $display("FAIL ld_alu_prio: got addr=%0h count=%0h exp addr=2 count=1", bus.o_wr_addr, bus.o_lq_count); end
        step();
        tests++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 5'd8 || bus.o_wr_data !== 32'h8888) begin
            fails++; $display("FAIL ld_after_alu: got en=%0h addr=%0h data=%0h exp en=1 addr=8 data=8888", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        step();
    endtask

    task automatic test_starvation();
        int   ld_idx;
        int   seen;
        logic acc;
        logic [4:0]  seen_rd   [3];
        logic [31:0] seen_data [3];
        ld_idx = 0;
        seen   = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 2) begin
                tests++; if (bus.o_lq_count !== 2'd2 || bus.o_ld_ready !== 1'b0) begin
                    fails++; $display("FAIL stv_full: got count=%0h ready=%0h exp count=2 ready=0", bus.o_lq_count, bus.o_ld_ready); end
            end
            if (k == 5) begin
                tests++; if (bus.o_alu_stall !== 1'b0) begin fails++; $display("FAIL stv_stall_early: got %0h exp 0", bus.o_alu_stall); end
            end
            if (k == 6) begin
                tests++; if (bus.o_alu_stall !== 1'b1) begin fails++; $display("FAIL stv_stall_rise: got %0h exp 1", bus.o_alu_stall); end
            end
            if (k == 7) begin
                tests++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 5'd10 || bus.o_wr_data !== 32'hA0 || bus.o_alu_stall !== 1'b0) begin
                    fails++; $display("FAIL stv_head_write: got en=%0h addr=%0h data=%0h stall=%0h exp en=1 addr=a data=a0 stall=0",
                                      bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_alu_stall); end
            end
            if (k == 8) begin
                tests++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 5'd1 || bus.o_wr_data !== 32'd7) begin
                    fails++; $display("FAIL stv_alu_resume: got en=%0h addr=%0h data=%0h exp en=1 addr=1 data=7", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
            end
            if (bus.o_wr_en === 1'b1 && bus.o_wr_addr >= 5'd10) begin
                if (seen < 3) begin
                    seen_rd[seen]   = bus.o_wr_addr;
                    seen_data[seen] = bus.o_wr_data;
                end
                seen++;
            end
            bus.i_alu_valid = (k < 14) && !bus.o_alu_stall;
            bus.i_alu_rd    = 5'd1;
            bus.i_alu_data  = 32'(k);
            bus.i_ld_valid  = (ld_idx < 3);
            bus.i_ld_rd     = 5'(10 + ld_idx);
            bus.i_ld_data   = 32'hA0 + 32'(ld_idx);
            acc = bus.i_ld_valid && bus.o_ld_ready;
            step();
            if (acc) ld_idx++;
        end
        idle_inputs();
        tests++; if (seen !== 3) begin fails++; $display("FAIL stv_load_count: got %0d exp 3", seen); end
        for (int i = 0; i < 3; i++) begin
            if (i < seen) begin
                tests++; if (seen_rd[i] !== 5'(10 + i) || seen_data[i] !== 32'hA0 + 32'(i)) begin
                    fails++; $display("FAIL stv_order_%0d: got addr=%0h data=%0h exp addr=%0h data=%0h",
                                      i, seen_rd[i], seen_data[i], 10 + i, 32'hA0 + 32'(i)); end
            end
        end
        tests++; if (bus.o_lq_count !== 2'd0) begin fails++; $display("FAIL stv_drained: got %0h exp 0", bus.o_lq_count); end
    endtask

    task automatic test_scoreboard();
        bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd9; bus.i_chk_addr1 = 5'd9; bus.i_chk_addr2 = 5'd0;
        step();
        bus.i_iss_valid = 1'b0;
        tests++; if (bus.o_busy1 !== c_SB) begin fails++; $display("FAIL sb_set: got %0h exp %0h", bus.o_busy1, c_SB); end
        tests++; if (bus.o_busy2 !== 1'b0) begin fails++; $display("FAIL sb_x0: got %0h exp 0", bus.o_busy2); end
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd9; bus.i_ld_data = 32'h99;
        step();
        bus.i_ld_valid = 1'b0;
        // Reissue rd 9 on the edge its load leaves the queue.
        bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd9;
        step();
        bus.i_iss_valid = 1'b0;
        tests++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 5'd9 || bus.o_wr_data !== 32'h99) begin
            fails++; $display("FAIL sb_ld_write: got en=%0h addr=%0h data=%0h exp en=1 addr=9 data=99", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        tests++; if (bus.o_busy1 !== c_SB) begin fails++; $display("FAIL sb_set_wins: got %0h exp %0h", bus.o_busy1, c_SB); end
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd9; bus.i_ld_data = 32'h98;
        step();
        bus.i_ld_valid = 1'b0;
        step();
        tests++; if (bus.o_busy1 !== 1'b0 || bus.o_wr_addr !== 5'd9 || bus.o_wr_data !== 32'h98) begin
            fails++; $display("FAIL sb_clear: got busy=%0h addr=%0h data=%0h exp busy=0 addr=9 data=98", bus.o_busy1, bus.o_wr_addr, bus.o_wr_data); end
        bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd0; bus.i_chk_addr1 = 5'd0;
        step();
        bus.i_iss_rd = 5'd4; bus.i_chk_addr2 = 5'd4;
        tests++; if (bus.o_busy1 !== 1'b0) begin fails++; $display("FAIL sb_iss_x0: got %0h exp 0", bus.o_busy1); end
        step();
        bus.i_iss_valid = 1'b0;
        tests++; if (bus.o_busy2 !== c_SB) begin fails++; $display("FAIL sb_rd4: got %0h exp %0h", bus.o_busy2, c_SB); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        do_reset();
        bus.i_iss_valid = 1'b1; bus.i_iss_rd = 5'd3; bus.i_chk_addr1 = 5'd3;
        bus.i_ld_valid = 1'b1; bus.i_ld_rd = 5'd3; bus.i_ld_data = 32'h33;
        bus.i_alu_valid = 1'b1; bus.i_alu_rd = 5'd1; bus.i_alu_data = 32'h11;
        step();
        bus.i_iss_valid = 1'b0;
        bus.i_ld_rd = 5'd4; bus.i_ld_data = 32'h44;
        step();
        bus.i_ld_valid = 1'b0; bus.i_alu_valid = 1'b0;
        tests++; if (bus.o_lq_count !== 2'd2 || bus.o_busy1 !== c_SB) begin
            fails++; $display("FAIL rm_pre: got count=%0h busy=%0h exp count=2 busy=%0h", bus.o_lq_count, bus.o_busy1, c_SB); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.o_lq_count !== 2'd0 || bus.o_ld_ready !== 1'b1 || bus.o_busy1 !== 1'b0 || bus.o_wr_en !== 1'b0) begin
            fails++; $display("FAIL rm_async: got count=%0h ready=%0h busy=%0h en=%0h exp count=0 ready=1 busy=0 en=0",
                              bus.o_lq_count, bus.o_ld_ready, bus.o_busy1, bus.o_wr_en); end
        repeat (2) step();
        rst_n = 1'b1;
        wr_seen = 0;
        repeat (5) begin
            step();
            if (bus.o_wr_en !== 1'b0) wr_seen++;
        end
        tests++; if (wr_seen != 0) begin fails++; $display("FAIL rm_no_writes: got %0d writes exp 0", wr_seen); end
        tests++; if (bus.o_lq_count !== 2'd0) begin fails++; $display("FAIL rm_count: got %0h exp 0", bus.o_lq_count); end
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        tests = 0;
        fails = 0;
        idle_inputs();
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_starvation();
        test_scoreboard();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter driving the single write port of the CPU's 2-read/1-write register file. It merges single-cycle ALU results with multi-cycle load results, buffers loads in a small queue, and drops writes to x0. An optional busy-bit scoreboard tracks outstanding load destinations for hazard checks in decode.

## Interface
Parameters:
- `LQ_DEPTH`, default 2: load-result queue depth; power of two, ≥2.
- `STARVE_MAX`, default 4: consecutive cycles the queue may stay full before ALU is stalled.

Ports:
- `clk` in 1: clock; single clock domain.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_alu_valid` in 1: ALU result present this cycle; never backpressured except via `o_alu_stall`.
- `i_alu_rd` in 5: ALU destination register.
- `i_alu_data` in 32: ALU result.
- `i_ld_valid` in 1: load result offered.
- `o_ld_ready` out 1: queue can accept a load result.
- `i_ld_rd` in 5: load destination register.
- `i_ld_data` in 32: load data.
- `i_iss_valid` in 1: load issued this cycle; marks `i_iss_rd` busy.
- `i_iss_rd` in 5: destination of the issued load.
- `i_chk_addr1`, `i_chk_addr2` in 5 each: scoreboard lookup addresses.
- `o_busy1`, `o_busy2` out 1 each: lookup register has a pending load.
- `o_alu_stall` out 1: upstream must hold `i_alu_valid` low next cycle.
- `o_wr_addr` out 5, `o_wr_data` out 32, `o_wr_en` out 1: register-file write port.
- `o_lq_count` out clog2(LQ_DEPTH)+1: queue occupancy.

## Operation
- Load accept: handshake occurs when `i_ld_valid && o_ld_ready`. Entries with `i_ld_rd==0` are consumed and discarded (not enqueued).
- `o_ld_ready = (count < LQ_DEPTH)`. It is combinational from registered count and does not depend on same-cycle dequeue.
- Queue: circular buffer with read/write pointers that wrap modulo LQ_DEPTH. Simultaneous enqueue and dequeue keeps count unchanged.
- Per-cycle slot selection, in priority order:
  1. `o_alu_stall` high and queue non-empty → queue head.
  2. `i_alu_valid && i_alu_rd!=0` → ALU.
  3. Queue non-empty → queue head.
  4. Otherwise idle.
- An ALU result with rd=0 never takes the slot; the queue head may use that cycle.
- Starvation counter: increments each cycle the queue is full and the head is not dequeued; otherwise clears. `o_alu_stall` is registered and goes high when the counter reaches STARVE_MAX−1. It drops the cycle after a dequeue.
- Protocol: `i_alu_valid` high while `o_alu_stall` is high is a violation. The ALU result is dropped and the queue head is written.
- Scoreboard: `busy[rd]` is set at the edge where `i_iss_valid && i_iss_rd!=0`. It is cleared at the edge where a load for that rd is dequeued to the write port.
  - Simultaneous set and clear of the same rd: set wins.
  - `busy[0]` is always 0.
  - `o_busyN = busy[i_chk_addrN]` (combinational).

## Timing
- The write port is registered. A result selected in cycle N appears on `o_wr_*` during cycle N+1, with `o_wr_en` high for exactly one cycle per write.
- ALU result to write port: 1 cycle.
- Load accepted at edge E: earliest `o_wr_en` is in the cycle following edge E+1 (2-cycle latency).
- `o_wr_addr`/`o_wr_data` hold their last values when `o_wr_en` is low.
- Reset values (async on `i_rst_n` low):
  - `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0.
  - Count=0, pointers=0, so `o_ld_ready`=1 and `o_lq_count`=0.
  - `o_alu_stall`=0, starvation counter=0, all busy bits=0.
- Reset mid-operation discards all queued loads and clears the scoreboard. No write is issued during or on the first edge after reset release.

## Configuration
- `RF_WB_SCOREBOARD_EN` defined: busy-bit scoreboard built as described.
- `RF_WB_SCOREBOARD_EN` undefined: no busy register; `o_busy1`/`o_busy2` are tied 0; `i_iss_*` and `i_chk_*` are ignored. Write-back behaviour is identical.

## Test plan
- After reset, ALU valid with rd=5, data=0xDEADBEEF → next cycle `o_wr_en`=1, addr=5, data=0xDEADBEEF. ALU rd=0 → `o_wr_en` stays 0.
- Load rd=7, data=0x1234 accepted with no ALU traffic → `o_wr_en` on the second cycle after accept, addr=7; `o_lq_count` goes 1 then 0.
- ALU valid every cycle while 3 loads are offered (LQ_DEPTH=2) → `o_ld_ready` drops at count=2. After 4 full cycles `o_alu_stall`=1, then the head is written with ALU held off, and all 3 loads eventually write in order.
- Issue rd=9 → `o_busy1`=1 for `i_chk_addr1`=9 the next cycle. Issue rd=9 again on the same edge its earlier load dequeues → busy remains 1. Issue rd=0 → `o_busy` for addr 0 stays 0.
- Assert reset with 2 loads queued and busy[3]=1 → `o_lq_count`=0, `o_ld_ready`=1, `o_busy`=0, no writes after release.
- Build without `RF_WB_SCOREBOARD_EN`, issue rd=4 and check addr 4 → `o_busy1`=0. The write-back sequence matches the scoreboard build.
